// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: cache address/return, decode handshake and execute redirect.
// master = fetch unit, slave = the surrounding cache/decode/execute side.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_ready;
   logic [DATA_W-1:0] ic_instr;
   logic              dec_valid;
   logic              dec_ready;
   logic [DATA_W-1:0] dec_instr;
   logic [31:0]       dec_pc;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              busy;

   modport master (
      output ic_addr, dec_valid, dec_instr, dec_pc, busy,
      input  ic_ready, ic_instr, dec_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  ic_addr, dec_valid, dec_instr, dec_pc, busy,
      output ic_ready, ic_instr, dec_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC / fetch stage: drives the I-cache word address, queues up to two returned
// instructions for decode, and flushes on execute redirects.
module instruction_fetch_unit #(
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                      iCLK,
   input logic                      iRST_n,
   instruction_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {F_ISSUE, F_BUSY, F_FULL, F_DRAIN} fstate_t;

   fstate_t           r_state;
   logic              r_busy;
   logic [31:0]       r_pc;
   logic [DATA_W-1:0] r_q_instr [2];
   logic [31:0]       r_q_pc    [2];
   logic [1:0]        r_count;

   logic              w_push;
   logic              w_pop;
   logic              w_wr_idx;
   logic [31:0]       w_redirect_pc;
   logic [1:0]        w_count_after;

   assign w_push        = (r_state == F_BUSY) && bus.ic_ready;
   assign w_pop         = (r_count != 2'd0) && bus.dec_ready;
   assign w_wr_idx      = r_count[0];
   assign w_redirect_pc = bus.redirect_pc & ~32'd3;
   assign w_count_after = r_count + {1'b0, w_push} - {1'b0, w_pop};

   assign bus.ic_addr   = r_pc[ADDR_W+1:2];
   assign bus.dec_valid = (r_count != 2'd0);
   assign bus.dec_instr = r_q_instr[0];
   assign bus.dec_pc    = r_q_pc[0];
   assign bus.busy      = r_busy;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state <= F_ISSUE;
         r_busy  <= 1'b1;
         r_pc    <= RESET_PC;
         r_count <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else if (bus.redirect_valid) begin
         r_count <= '0;
         r_pc    <= w_redirect_pc;
         r_busy  <= 1'b1;
         case (r_state)
            F_BUSY:  r_state <= F_DRAIN;
            F_ISSUE: r_state <= bus.ic_ready ? F_ISSUE : F_DRAIN;
            F_FULL:  r_state <= F_ISSUE;
            default: r_state <= F_DRAIN;
         endcase
      end else begin
         // Head lives in slot 0; pushes only happen with <=1 entry held, so
         // push+pop always lands the new entry directly in the head slot.
         if (w_push && w_pop) begin
            r_q_instr[0] <= bus.ic_instr;
            r_q_pc[0]    <= r_pc;
         end else if (w_push) begin
            r_q_instr[w_wr_idx] <= bus.ic_instr;
            r_q_pc[w_wr_idx]    <= r_pc;
         end else if (w_pop) begin
            r_q_instr[0] <= r_q_instr[1];
            r_q_pc[0]    <= r_q_pc[1];
         end
         r_count <= w_count_after;

         case (r_state)
            F_ISSUE: begin
               if (!bus.ic_ready) r_state <= F_BUSY;
            end
            F_BUSY: begin
               if (bus.ic_ready) begin
                  r_pc <= r_pc + 32'd4;
                  if (w_count_after == 2'd2) begin
                     r_state <= F_FULL;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= F_ISSUE;
                  end
               end
            end
            F_FULL: begin
               if (w_pop) begin
                  r_state <= F_ISSUE;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               if (bus.ic_ready) r_state <= F_ISSUE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cache model, stream scoreboard, redirect
// vector table and directed stall/reset sequences, then randomized traffic.
module tb_instruction_fetch_unit;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int LAT    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   instruction_fetch_unit #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .iCLK  (clk),
      .iRST_n(rst_n),
      .bus   (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          mode  = 0;
   int          cache_cnt = 0;
   logic [7:0]  cache_addr = '0;
   logic        mon_en = 1'b0;
   logic [31:0] exp_pc = '0;
   logic        hold_prev = 1'b0;
   logic [31:0] held_pc = '0;
   logic [31:0] held_instr = '0;
   int          pops = 0;

   typedef struct {
      logic        full_mode;
      logic [31:0] rpc;
      logic [7:0]  exp_addr;
      logic [31:0] exp_pc0;
      logic [7:0]  exp_addr1;
      logic [31:0] exp_pc1;
   } vec_t;
   vec_t vecs [5];

   function automatic logic [31:0] mem(input logic [7:0] a);
      if (mode == 0) return 32'h0000_0013;
      return {16'hC0DE, 8'h00, a} ^ {a, 24'h000000};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: decode sees a gap-free PC stream that restarts at each redirect.
   task automatic monitor();
      if (mon_en && rst_n) begin
         if (hold_prev) begin
            chk("stall_valid", {31'd0, bus.dec_valid}, 32'd1);
            chk("stall_pc", bus.dec_pc, held_pc);
            chk("stall_instr", bus.dec_instr, held_instr);
         end
         if (bus.dec_valid) chk("instr_vs_mem", bus.dec_instr, mem(bus.dec_pc[9:2]));
         if (bus.redirect_valid) begin
            exp_pc = bus.redirect_pc & ~32'd3;
         end else if (bus.dec_valid && bus.dec_ready) begin
            chk("stream_pc", bus.dec_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         hold_prev  = bus.dec_valid && !bus.dec_ready && !bus.redirect_valid;
         held_pc    = bus.dec_pc;
         held_instr = bus.dec_instr;
      end
   endtask

   task automatic cache_step();
      if (!rst_n) begin
         bus.ic_ready = 1'b1;
         cache_cnt    = 0;
      end else if (cache_cnt > 0) begin
         cache_cnt--;
         if (cache_cnt == 0) begin
            bus.ic_ready = 1'b1;
            bus.ic_instr = mem(cache_addr);
         end
      end else if (bus.busy && bus.ic_ready) begin
         cache_addr   = bus.ic_addr;
         bus.ic_ready = 1'b0;
         bus.ic_instr = 32'hDEAD_BEEF;
         cache_cnt    = LAT;
      end
   endtask

   task automatic cycle();
      monitor();
      @(posedge clk);
      #1;
      cache_step();
   endtask

   task automatic do_reset(input int m);
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.dec_ready      = 1'b0;
      mode               = m;
      exp_pc             = 32'h0;
      hold_prev          = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string name, input int lim);
      int n = 0;
      while (!bus.dec_valid && n < lim) begin
         cycle();
         n++;
      end
      if (!bus.dec_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_full(input string name, input int lim);
      int n = 0;
      while (bus.busy && n < lim) begin
         cycle();
         n++;
      end
      if (bus.busy) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_cache_pending(input string name, input int lim);
      int n = 0;
      while (bus.ic_ready && n < lim) begin
         cycle();
         n++;
      end
      if (bus.ic_ready) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0042, 8'h10, 32'h0000_0040, 8'h11, 32'h0000_0044};
      vecs[1] = '{1'b1, 32'h0000_0200, 8'h80, 32'h0000_0200, 8'h81, 32'h0000_0204};
      vecs[2] = '{1'b0, 32'hFFFF_FFFC, 8'hFF, 32'hFFFF_FFFC, 8'h00, 32'h0000_0000};
      vecs[3] = '{1'b0, 32'h1234_5679, 8'h9E, 32'h1234_5678, 8'h9F, 32'h1234_567C};
      vecs[4] = '{1'b1, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFC, 8'h00, 32'h0000_0000};

      bus.ic_ready       = 1'b1;
      bus.ic_instr       = '0;
      bus.dec_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      mon_en             = 1'b1;

      // Reset state and in-order stream with constant cache data
      do_reset(0);
      chk("rst_valid", {31'd0, bus.dec_valid}, 32'd0);
      chk("rst_instr", bus.dec_instr, 32'd0);
      chk("rst_pc", bus.dec_pc, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      chk("rst_addr", {24'd0, bus.ic_addr}, 32'd0);
      bus.dec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid("seq", 40);
         chk("seq_pc", bus.dec_pc, 32'(k * 4));
         chk("seq_instr", bus.dec_instr, 32'h0000_0013);
         chk("seq_addr", {24'd0, bus.ic_addr}, 32'(k + 1));
         cycle();
      end

      // Long stall: queue fills to two entries and fetch stops
      do_reset(0);
      for (int k = 0; k < 40; k++) cycle();
      chk("full_busy", {31'd0, bus.busy}, 32'd0);
      chk("full_valid", {31'd0, bus.dec_valid}, 32'd1);
      chk("full_head", bus.dec_pc, 32'h0);
      chk("full_addr", {24'd0, bus.ic_addr}, 32'd2);
      bus.dec_ready = 1'b1;
      cycle();
      chk("full_second_valid", {31'd0, bus.dec_valid}, 32'd1);
      chk("full_second_pc", bus.dec_pc, 32'h4);
      cycle();
      chk("full_drained", {31'd0, bus.dec_valid}, 32'd0);
      chk("full_resume_busy", {31'd0, bus.busy}, 32'd1);

      // Redirect table: taken either mid-fetch or with a full queue plus pop
      do_reset(1);
      bus.dec_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].full_mode) begin
            bus.dec_ready = 1'b0;
            wait_full("tbl_full", 60);
            chk("tbl_full_valid", {31'd0, bus.dec_valid}, 32'd1);
            bus.dec_ready = 1'b1;
         end else begin
            wait_valid("tbl_pre", 60);
            cycle();
            wait_cache_pending("tbl_pend", 60);
            cycle();
         end
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = vecs[v].rpc;
         cycle();
         bus.redirect_valid = 1'b0;
         chk("tbl_flush", {31'd0, bus.dec_valid}, 32'd0);
         chk("tbl_addr", {24'd0, bus.ic_addr}, {24'd0, vecs[v].exp_addr});
         wait_valid("tbl_first", 60);
         chk("tbl_pc0", bus.dec_pc, vecs[v].exp_pc0);
         chk("tbl_instr0", bus.dec_instr, mem(vecs[v].exp_addr));
         chk("tbl_addr1", {24'd0, bus.ic_addr}, {24'd0, vecs[v].exp_addr1});
         cycle();
         wait_valid("tbl_second", 60);
         chk("tbl_pc1", bus.dec_pc, vecs[v].exp_pc1);
         cycle();
      end

      // Asynchronous reset while a fetch is outstanding with one entry queued
      do_reset(0);
      wait_valid("mid_pre", 40);
      cycle();
      chk("mid_pre_addr", {24'd0, bus.ic_addr}, 32'd1);
      chk("mid_pre_pending", {31'd0, bus.ic_ready}, 32'd0);
      rst_n     = 1'b0;
      hold_prev = 1'b0;
      exp_pc    = 32'h0;
      #2;
      chk("mid_rst_valid", {31'd0, bus.dec_valid}, 32'd0);
      chk("mid_rst_addr", {24'd0, bus.ic_addr}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd1);
      cycle();
      cycle();
      rst_n         = 1'b1;
      bus.dec_ready = 1'b1;
      wait_valid("mid_restart", 40);
      chk("mid_restart_pc", bus.dec_pc, 32'h0);
      chk("mid_restart_instr", bus.dec_instr, 32'h0000_0013);
      cycle();

      // Randomized backpressure and redirects against the stream reference
      do_reset(1);
      pops = 0;
      for (int c = 0; c < 900; c++) begin
         bus.dec_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 24) == 0) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = $urandom;
         end else begin
            bus.redirect_valid = 1'b0;
         end
         cycle();
      end
      bus.redirect_valid = 1'b0;
      chk("random_progress", 32'(pops > 30), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Program-counter and fetch stage that drives the word address into the instruction cache and collects the returned instructions.
- Buffers up to two fetched instructions in a queue and presents them, with their byte PC, to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any stale or in-flight instructions.
- Sits directly upstream of the instruction cache (it owns the cache's address input) and downstream of nothing but reset.

Parameters:
- ADDR_W, 8, width of the word address driven to the instruction cache.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset; bits [1:0] must be 0.

Ports:
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST_n  in  1  reset; asynchronous, active-low.
- ic_addr  out  ADDR_W  word address to the cache, equal to pc[ADDR_W+1:2].
- ic_ready  in  1  cache not-busy level; low while a fetch is pending, high when ic_instr is valid.
- ic_instr  in  DATA_W  instruction returned by the cache.
- dec_valid  out  1  queue head is valid.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  DATA_W  queue head instruction.
- dec_pc  out  32  byte PC of the queue head.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  32  new byte PC; bits [1:0] are ignored and forced to 0.
- busy  out  1  high in F_ISSUE, F_BUSY and F_DRAIN.

Behaviour:
- Reset (async): pc=RESET_PC, queue empty, dec_valid=0, dec_instr=0, dec_pc=0, state=F_ISSUE, busy=1, ic_addr=RESET_PC[ADDR_W+1:2].
- ic_addr is combinational from pc and is held stable for the whole fetch.
- Fetch FSM:
  - F_ISSUE: wait for ic_ready==0 (cache has accepted the request), then go to F_BUSY.
  - F_BUSY: on the first cycle with ic_ready==1, push {ic_instr, pc} into the queue and set pc<=pc+4 (mod 2^32). If the queue is then full (2 entries), go to F_FULL; otherwise go to F_ISSUE.
  - F_FULL: no fetch in progress, busy=0. On a pop, go to F_ISSUE.
  - F_DRAIN: discards an in-flight result. Wait for ic_ready==1 with no push, then go to F_ISSUE.
- Queue:
  - 2-entry FIFO; dec_* always reflect the head entry.
  - A pop occurs when dec_valid && dec_ready.
  - A push and a pop in the same cycle are both legal; occupancy stays unchanged.
  - A push is never attempted while the queue holds 2 entries, because F_FULL gates it.
- Redirect (redirect_valid==1), which overrides all other events that cycle:
  - Flush the queue: dec_valid=0 next cycle, and any same-cycle push or pop is discarded.
  - Load pc<={redirect_pc[31:2],2'b00}.
  - From F_BUSY go to F_DRAIN; from F_ISSUE go to F_DRAIN if ic_ready==0 that cycle, else stay in F_ISSUE; from F_FULL go to F_ISSUE.
  - A redirect arriving while in F_DRAIN only updates pc and stays in F_DRAIN.
- Latency and throughput:
  - The first instruction appears on dec_valid one cycle after the ic_ready rising edge.
  - Throughput is bounded by the cache, roughly 1 instruction per 4 cycles on a hit.
- Wrap-around: pc=32'hFFFF_FFFC increments to 0, and ic_addr wraps modulo 2^ADDR_W.
- Reset asserted mid-fetch: all state clears immediately, and the pending cache result is ignored through the F_ISSUE handshake.
- dec_pc/dec_instr must remain stable while dec_valid && !dec_ready.

Test Plan:
- Reset then release with the cache model returning ic_instr=0x00000013 for every address, dec_ready=1 -> dec_pc sequence 0x0, 0x4, 0x8 with dec_instr=0x13 each; ic_addr steps 0, 1, 2.
- dec_ready=0 for 40 cycles -> exactly 2 entries queued (pc 0x0, 0x4); FSM enters F_FULL with busy=0; ic_addr holds at 2 until dec_ready is raised, then the entries pop in order.
- Redirect to 0x0000_0042 while in F_BUSY -> in-flight instruction discarded, next dec_pc=0x40, ic_addr=0x10; no entry for pc 0x4 appears.
- Redirect in the same cycle as a pop with the queue full -> queue empty next cycle; the next output is the redirect target only.
- Redirect to 0xFFFF_FFFC with ADDR_W=8 -> dec_pc 0xFFFFFFFC then 0x00000000; ic_addr 0xFF then 0x00.
- Assert iRST_n=0 while in F_BUSY with 1 entry queued -> dec_valid=0 asynchronously; after release the fetch restarts at RESET_PC.
